// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: counts rising edges of sig_in over a GATE_CYCLES-long gate
// window and publishes the count as a saturating 4-digit packed BCD word.
// Optional build macro FREQ_HOLD_EN adds a `hold` input that freezes the
// published result at end-of-window while counting carries on.
module freq_meter_bcd #(
  parameter int unsigned GATE_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sig_in,
`ifdef FREQ_HOLD_EN
  input  logic        hold,
`endif
  output logic [15:0] freq,
  output logic        valid,
  output logic        overflow
);

  logic        s1_q, s2_q, s3_q;
  logic [31:0] gate_q;
  logic [15:0] acc_q, acc_d;
  logic        sat_q, sat_d;
  logic [15:0] freq_q;
  logic        valid_q, overflow_q;

  logic        edge_det;
  logic        end_win;
  logic        publish;
  logic [15:0] inc_val;
  logic        inc_sat;
  logic        carry;

  assign edge_det = s2_q & ~s3_q;
  assign end_win  = (gate_q == 32'(GATE_CYCLES - 1));

`ifdef FREQ_HOLD_EN
  assign publish = end_win & ~hold;
`else
  assign publish = end_win;
`endif

  // BCD increment with ripple carry; 9999 stays put and flags saturation
  always_comb begin
    inc_val = acc_q;
    inc_sat = 1'b0;
    carry   = 1'b1;
    if (acc_q == 16'h9999) begin
      inc_sat = 1'b1;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (acc_q[4*i +: 4] == 4'd9) begin
            inc_val[4*i +: 4] = 4'd0;
          end else begin
            inc_val[4*i +: 4] = acc_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  // Accumulator value including this cycle's edge; feeds both the running
  // count and the end-of-window result so a boundary edge is never lost
  always_comb begin
    acc_d = edge_det ? inc_val : acc_q;
    sat_d = sat_q | (edge_det & inc_sat);
  end

  // Input synchronizer and edge-delay flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Gate counter, accumulator and published result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_q     <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= publish;
      if (end_win) begin
        gate_q <= '0;
        acc_q  <= '0;
        sat_q  <= 1'b0;
      end else begin
        gate_q <= gate_q + 32'd1;
        acc_q  <= acc_d;
        sat_q  <= sat_d;
      end
      if (publish) begin
        freq_q     <= acc_d;
        overflow_q <= sat_d;
      end
    end
  end

  assign freq     = freq_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Directed bench for freq_meter_bcd: a short-gate instance (100 cycles) for
// timing, reset and boundary behaviour, and a long-gate instance (20010
// cycles) for saturation and recovery.
module tb_freq_meter_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sig_a = 1'b0;
  logic        sig_b = 1'b0;
  logic [15:0] freq_a, freq_b;
  logic        valid_a, valid_b;
  logic        ovf_a, ovf_b;
`ifdef FREQ_HOLD_EN
  logic        hold_a = 1'b0;
  logic        hold_b = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n = 0;
  int pa = 0, a_base = 0;
  int pb = 0, b_base = 0;
  int vcnt_a = 0;

  always #5 clk = ~clk;

  freq_meter_bcd #(.GATE_CYCLES(100)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .sig_in  (sig_a),
`ifdef FREQ_HOLD_EN
    .hold    (hold_a),
`endif
    .freq    (freq_a),
    .valid   (valid_a),
    .overflow(ovf_a)
  );

  freq_meter_bcd #(.GATE_CYCLES(20010)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .sig_in  (sig_b),
`ifdef FREQ_HOLD_EN
    .hold    (hold_b),
`endif
    .freq    (freq_b),
    .valid   (valid_b),
    .overflow(ovf_b)
  );

  // count valid pulses of the short-gate instance, sampled mid-cycle
  always @(negedge clk) if (valid_a === 1'b1) vcnt_a++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_sigs();
    if (pa != 0) sig_a = (((n - a_base) % pa) < (pa / 2));
    if (pb != 0) sig_b = (((n - b_base) % pb) < (pb / 2));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    apply_sigs();
  endtask

  task automatic run_to(input int t);
    while (n < t) step();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    n      = 0;
    vcnt_a = 0;
    apply_sigs();
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // asynchronous reset with no clock edge
    #3;
    reset = 1'b1;
    #1;
    chk("rst_freq_a", 32'(freq_a), 32'h0000);
    chk("rst_valid_a", 32'(valid_a), 32'h0);
    chk("rst_ovf_a", 32'(ovf_a), 32'h0);
    chk("rst_freq_b", 32'(freq_b), 32'h0000);

    // period-10 input, free running
    pa = 10; a_base = 0;
    release_rst();
    run_to(99);
    chk("w0_hold_freq", 32'(freq_a), 32'h0000);
    chk("w0_no_valid", 32'(vcnt_a), 32'd0);
    step();
    chk("w0_freq", 32'(freq_a), 32'h0010);
    chk("w0_valid", 32'(valid_a), 32'h1);
    chk("w0_ovf", 32'(ovf_a), 32'h0);
    step();
    chk("w0_valid_drop", 32'(valid_a), 32'h0);
    run_to(199);
    chk("w1_one_pulse", 32'(vcnt_a), 32'd1);
    step();
    chk("w1_freq", 32'(freq_a), 32'h0010);
    chk("w1_valid", 32'(valid_a), 32'h1);

    // reset mid-window discards partial count
    run_to(250);
    mid_reset();
    chk("mid_rst_freq", 32'(freq_a), 32'h0000);
    chk("mid_rst_valid", 32'(valid_a), 32'h0);
    release_rst();
    run_to(99);
    chk("mr_no_valid", 32'(vcnt_a), 32'd0);
    chk("mr_hold_freq", 32'(freq_a), 32'h0000);
    step();
    chk("mr_freq", 32'(freq_a), 32'h0010);
    chk("mr_valid", 32'(valid_a), 32'h1);

    // single edge then steady high
    mid_reset();
    pa = 0;
    sig_a = 1'b0;
    release_rst();
    run_to(5);
    sig_a = 1'b1;
    run_to(100);
    chk("one_edge_freq", 32'(freq_a), 32'h0001);
    run_to(200);
    chk("steady_freq", 32'(freq_a), 32'h0000);
    chk("steady_valid", 32'(valid_a), 32'h1);
    chk("steady_ovf", 32'(ovf_a), 32'h0);

    // pulses detected at edges 298, 300 (window end) and 302
    run_to(201);
    sig_a = 1'b0;
    run_to(295);
    sig_a = 1'b1; step();
    sig_a = 1'b0; step();
    sig_a = 1'b1; step();
    sig_a = 1'b0; step();
    sig_a = 1'b1; step();
    sig_a = 1'b0;
    chk("bnd_w2_freq", 32'(freq_a), 32'h0002);
    chk("bnd_w2_valid", 32'(valid_a), 32'h1);
    run_to(400);
    chk("bnd_w3_freq", 32'(freq_a), 32'h0001);

`ifdef FREQ_HOLD_EN
    // hold across one boundary suppresses the update
    mid_reset();
    pa = 10; a_base = 0;
    release_rst();
    run_to(99);
    pa = 20; a_base = 100;
    step();
    chk("hold_w0_freq", 32'(freq_a), 32'h0010);
    run_to(199);
    hold_a = 1'b1;
    step();
    hold_a = 1'b0;
    chk("hold_freq", 32'(freq_a), 32'h0010);
    chk("hold_no_valid", 32'(valid_a), 32'h0);
    run_to(300);
    chk("unhold_freq", 32'(freq_a), 32'h0005);
    chk("unhold_valid", 32'(valid_a), 32'h1);
`endif

    // saturation on the long-gate instance, then recovery at period 30
    mid_reset();
    pa = 0;
    sig_a = 1'b0;
    pb = 2; b_base = 0;
    release_rst();
    run_to(20009);
    pb = 30; b_base = 20010;
    step();
    chk("sat_freq", 32'(freq_b), 32'h9999);
    chk("sat_ovf", 32'(ovf_b), 32'h1);
    chk("sat_valid", 32'(valid_b), 32'h1);
    run_to(40020);
    chk("trans_freq", 32'(freq_b), 32'h0668);
    chk("trans_ovf", 32'(ovf_b), 32'h0);
    run_to(60030);
    chk("p30_freq", 32'(freq_b), 32'h0667);
    chk("p30_ovf", 32'(ovf_b), 32'h0);
    chk("p30_valid", 32'(valid_b), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
